// File: rtl/instr_mem.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem
// Purpose  : Parametrised instruction memory for the RISC-V core.
//
//            - Fetch results are registered, so data appears one cycle after
//              the request edge.
//            - fetch_hold stalls the fetch outputs.
//            - A runtime load port writes program words.
//            - After reset, a fill sequencer writes HALT_WORD into every word.
//            - Misaligned and out-of-range fetches are flagged.
//
// Ports    : clk, rst_n (async, active low)
//            fetch_req, fetch_addr[31:0], fetch_hold      -> fetch request
//            fetch_ready, fetch_valid, fetch_instr, fetch_err <- fetch result
//            load_we, load_addr[ADDR_W-1:0], load_data    -> program load
//            fill_busy                                    <- fill in progress
//            load_perr_inj / fetch_perr                   (IMEM_PARITY_EN only)
//
// Config   : Define IMEM_PARITY_EN to store an even-parity bit per word.
//            Defining it also adds the load_perr_inj input and the
//            fetch_perr output.
//
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem #(
    parameter int unsigned       ADDR_W    = 5,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'h0000007f,
    parameter logic [DATA_W-1:0] NOP_WORD  = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    input  logic              fetch_hold,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_err,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
`ifdef IMEM_PARITY_EN
    input  logic              load_perr_inj,
    output logic              fetch_perr,
`endif
    output logic              fill_busy
);

    localparam int unsigned c_depth = 2 ** ADDR_W;
`ifdef IMEM_PARITY_EN
    localparam int unsigned c_word_w = DATA_W + 1;   // parity bit in the MSB
`else
    localparam int unsigned c_word_w = DATA_W;
`endif
    localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(c_depth - 1);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t              state_q,       state_d;
    logic [ADDR_W-1:0]   cnt_q,         cnt_d;
    logic                fetch_valid_q, fetch_valid_d;
    logic [DATA_W-1:0]   fetch_instr_q, fetch_instr_d;
    logic                fetch_err_q,   fetch_err_d;
    logic                fetch_ready_q, fetch_ready_d;
    logic                fill_busy_q,   fill_busy_d;
`ifdef IMEM_PARITY_EN
    logic                fetch_perr_q,  fetch_perr_d;
`endif

    logic [c_word_w-1:0] mem_q [c_depth];

    // Memory write port, shared by the fill sequencer and the load port
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [c_word_w-1:0] mem_wdata;

    // Fetch decode
    logic                addr_aligned;
    logic                addr_in_range;
    logic [c_word_w-1:0] rd_word;

    assign addr_aligned  = (fetch_addr[1:0] == 2'b00);
    // Every bit above the word index takes part in the range check, so
    // aliased addresses such as 0x2000_0008 are flagged as out of range.
    assign addr_in_range = (fetch_addr[31:ADDR_W+2] == '0);
    // The memory is read combinationally and the result is captured in the
    // output register. A load to the same word lands on the same edge, so
    // the fetch returns the old word (read-before-write).
    assign rd_word       = mem_q[fetch_addr[ADDR_W+1:2]];

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        fetch_valid_d = fetch_valid_q;
        fetch_instr_d = fetch_instr_q;
        fetch_err_d   = fetch_err_q;
        fetch_ready_d = fetch_ready_q;
        fill_busy_d   = fill_busy_q;
`ifdef IMEM_PARITY_EN
        fetch_perr_d  = fetch_perr_q;
`endif
        mem_we        = 1'b0;
        mem_waddr     = cnt_q;
`ifdef IMEM_PARITY_EN
        mem_wdata     = {^HALT_WORD, HALT_WORD};
`else
        mem_wdata     = HALT_WORD;
`endif

        case (state_q)
            ST_FILL: begin
                // The fill writes one word per cycle. Fetch and load inputs
                // are ignored while it runs.
                mem_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == c_last_idx) begin
                    state_d       = ST_RUN;
                    fetch_ready_d = 1'b1;
                    fill_busy_d   = 1'b0;
                end
            end

            ST_RUN: begin
                if (load_we) begin
                    mem_we    = 1'b1;
                    mem_waddr = load_addr;
`ifdef IMEM_PARITY_EN
                    mem_wdata = {(^load_data) ^ load_perr_inj, load_data};
`else
                    mem_wdata = load_data;
`endif
                end

                if (!fetch_hold) begin
                    if (fetch_req) begin
                        fetch_valid_d = 1'b1;
                        if (!addr_aligned) begin
                            fetch_instr_d = NOP_WORD;
                            fetch_err_d   = 1'b1;
`ifdef IMEM_PARITY_EN
                            fetch_perr_d  = 1'b0;
`endif
                        end else if (!addr_in_range) begin
                            fetch_instr_d = HALT_WORD;
                            fetch_err_d   = 1'b1;
`ifdef IMEM_PARITY_EN
                            fetch_perr_d  = 1'b0;
`endif
                        end else begin
                            fetch_instr_d = rd_word[DATA_W-1:0];
                            fetch_err_d   = 1'b0;
`ifdef IMEM_PARITY_EN
                            // Even parity over data and stored bit must be 0
                            fetch_perr_d  = ^rd_word;
`endif
                        end
                    end else begin
                        // Idle cycle: valid drops, data and error stay
                        fetch_valid_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_FILL;
            cnt_q         <= '0;
            fetch_valid_q <= 1'b0;
            fetch_instr_q <= HALT_WORD;
            fetch_err_q   <= 1'b0;
            fetch_ready_q <= 1'b0;
            fill_busy_q   <= 1'b1;
`ifdef IMEM_PARITY_EN
            fetch_perr_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_instr_q <= fetch_instr_d;
            fetch_err_q   <= fetch_err_d;
            fetch_ready_q <= fetch_ready_d;
            fill_busy_q   <= fill_busy_d;
`ifdef IMEM_PARITY_EN
            fetch_perr_q  <= fetch_perr_d;
`endif
        end
    end

    // Storage array. It has no reset because the fill sequencer initialises it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign fetch_ready = fetch_ready_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_instr = fetch_instr_q;
    assign fetch_err   = fetch_err_q;
    assign fill_busy   = fill_busy_q;
`ifdef IMEM_PARITY_EN
    assign fetch_perr  = fetch_perr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem
// Purpose  : Self-checking testbench for instr_mem. It combines directed
//            scenarios with a randomized run against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem;

    localparam int          ADDR_W = 5;
    localparam int          DEPTH  = 32;
    localparam logic [31:0] HALT   = 32'h0000007f;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_hold;
    logic        load_we;
    logic [4:0]  load_addr;
    logic [31:0] load_data;
    logic        load_perr_inj;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_err;
    logic        fill_busy;
`ifdef IMEM_PARITY_EN
    logic        fetch_perr;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    instr_mem #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_hold  (fetch_hold),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_err   (fetch_err),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data),
`ifdef IMEM_PARITY_EN
        .load_perr_inj(load_perr_inj),
        .fetch_perr  (fetch_perr),
`endif
        .fill_busy   (fill_busy)
    );

    // ------------------------------------------------------------------------
    // Reference model. Memory is an array of words plus a "bad parity" flag.
    // Outputs are computed from the address rules using plain arithmetic.
    // ------------------------------------------------------------------------
    logic [31:0] m_mem [DEPTH];
    bit          m_bad [DEPTH];
    bit          m_ready;
    int          m_fill;
    logic        exp_valid, exp_err, exp_perr;
    logic [31:0] exp_instr;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = HALT;
            m_bad[i] = 1'b0;
        end
        m_ready   = 1'b0;
        m_fill    = 0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_perr  = 1'b0;
        exp_instr = HALT;
    endtask

    task automatic idle_inputs();
        fetch_req     = 1'b0;
        fetch_addr    = 32'h0;
        fetch_hold    = 1'b0;
        load_we       = 1'b0;
        load_addr     = '0;
        load_data     = 32'h0;
        load_perr_inj = 1'b0;
    endtask

    // Advance one clock. The model is updated from the inputs applied
    // before the edge, and outputs are sampled 1 ns after the edge.
    task automatic step();
        if (m_ready && !fetch_hold) begin
            if (fetch_req) begin
                exp_valid = 1'b1;
                if (fetch_addr % 4 != 0) begin
                    exp_instr = NOP;  exp_err = 1'b1; exp_perr = 1'b0;
                end else if (fetch_addr / 4 >= DEPTH) begin
                    exp_instr = HALT; exp_err = 1'b1; exp_perr = 1'b0;
                end else begin
                    exp_instr = m_mem[fetch_addr / 4];
                    exp_err   = 1'b0;
                    exp_perr  = m_bad[fetch_addr / 4];
                end
            end else begin
                exp_valid = 1'b0;
            end
        end
        if (m_ready && load_we) begin
            m_mem[load_addr] = load_data;
            m_bad[load_addr] = load_perr_inj;
        end
        if (!m_ready) begin
            m_fill++;
            if (m_fill == DEPTH) m_ready = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic assert_reset();
        #2;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #2;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        int  n;
        bit  quiet;
        assert_reset();
        tests_run++;
        if ({fetch_valid, fetch_err, fetch_ready, fill_busy, fetch_instr} !== {4'b0001, HALT}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b e=%b rdy=%b busy=%b i=%h, need v=0 e=0 rdy=0 busy=1 i=%h",
                     fetch_valid, fetch_err, fetch_ready, fill_busy, fetch_instr, HALT);
        end
        release_reset();
        // Fetch and load activity during the fill must be ignored
        fetch_req = 1'b1; fetch_addr = 32'h0;
        load_we = 1'b1; load_addr = 5'd0; load_data = 32'hdeadbeef;
        n = 0; quiet = 1'b1;
        while (fill_busy === 1'b1 && n < 100) begin
            if (fetch_ready !== 1'b0 || fetch_valid !== 1'b0) quiet = 1'b0;
            step();
            n++;
        end
        idle_inputs();
        tests_run++;
        if (n != 32) begin
            tests_failed++;
            $display("FAIL fill_cycles: got %0d busy cycles, need 32", n);
        end
        tests_run++;
        if (!quiet || fetch_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL fill_ready: quiet=%b ready=%b, need quiet=1 ready=1", quiet, fetch_ready);
        end
        fetch_req = 1'b1; fetch_addr = 32'h7c;
        step();
        tests_run++;
        if ({fetch_valid, fetch_err, fetch_instr} !== {2'b10, HALT}) begin
            tests_failed++;
            $display("FAIL fetch_7c: got v=%b e=%b i=%h, need v=1 e=0 i=%h", fetch_valid, fetch_err, fetch_instr, HALT);
        end
        fetch_addr = 32'h0;
        step();
        tests_run++;
        if ({fetch_valid, fetch_err, fetch_instr} !== {2'b10, HALT}) begin
            tests_failed++;
            $display("FAIL fill_ignores_load: got v=%b e=%b i=%h, need v=1 e=0 i=%h", fetch_valid, fetch_err, fetch_instr, HALT);
        end
        idle_inputs();
    endtask

    task automatic test_load_fetch();
        load_we = 1'b1; load_addr = 5'd2; load_data = 32'h00c000ef;
        step();
        load_we = 1'b0;
        fetch_req = 1'b1; fetch_addr = 32'h8;
        step();
        tests_run++;
        if ({fetch_valid, fetch_err, fetch_instr} !== {2'b10, 32'h00c000ef}) begin
            tests_failed++;
            $display("FAIL load_fetch: got v=%b e=%b i=%h, need v=1 e=0 i=00c000ef", fetch_valid, fetch_err, fetch_instr);
        end
        fetch_req = 1'b0;
        step();
        tests_run++;
        if ({fetch_valid, fetch_err, fetch_instr} !== {2'b00, 32'h00c000ef}) begin
            tests_failed++;
            $display("FAIL idle_keep: got v=%b e=%b i=%h, need v=0 e=0 i=00c000ef", fetch_valid, fetch_err, fetch_instr);
        end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [5] = '{32'h6, 32'h80, 32'h20000008, 32'h7d, 32'h7c};
        logic [31:0] instrs[5] = '{NOP, HALT, HALT, NOP, HALT};
        logic        errs  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            fetch_req = 1'b1; fetch_addr = addrs[i];
            step();
            tests_run++;
            if ({fetch_valid, fetch_err, fetch_instr} !== {1'b1, errs[i], instrs[i]}) begin
                tests_failed++;
                $display("FAIL addr_rule %h: got v=%b e=%b i=%h, need v=1 e=%b i=%h",
                         addrs[i], fetch_valid, fetch_err, fetch_instr, errs[i], instrs[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_read_before_write();
        load_we = 1'b1; load_addr = 5'd3; load_data = 32'h00900113;
        fetch_req = 1'b1; fetch_addr = 32'hc;
        step();
        tests_run++;
        if ({fetch_valid, fetch_err, fetch_instr} !== {2'b10, HALT}) begin
            tests_failed++;
            $display("FAIL rbw_old: got v=%b e=%b i=%h, need v=1 e=0 i=%h", fetch_valid, fetch_err, fetch_instr, HALT);
        end
        load_we = 1'b0;
        step();
        tests_run++;
        if ({fetch_valid, fetch_err, fetch_instr} !== {2'b10, 32'h00900113}) begin
            tests_failed++;
            $display("FAIL rbw_new: got v=%b e=%b i=%h, need v=1 e=0 i=00900113", fetch_valid, fetch_err, fetch_instr);
        end
        idle_inputs();
    endtask

    task automatic test_hold();
        fetch_req = 1'b1; fetch_addr = 32'h8;
        step();
        fetch_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_addr = (i == 1) ? 32'h6 : 32'h80 + 32'(i);
            fetch_req  = (i != 2);
            step();
            tests_run++;
            if ({fetch_valid, fetch_err, fetch_instr} !== {2'b10, 32'h00c000ef}) begin
                tests_failed++;
                $display("FAIL hold_freeze %0d: got v=%b e=%b i=%h, need v=1 e=0 i=00c000ef",
                         i, fetch_valid, fetch_err, fetch_instr);
            end
        end
        fetch_hold = 1'b0; fetch_req = 1'b1; fetch_addr = 32'hc;
        step();
        tests_run++;
        if ({fetch_valid, fetch_err, fetch_instr} !== {2'b10, 32'h00900113}) begin
            tests_failed++;
            $display("FAIL hold_release: got v=%b e=%b i=%h, need v=1 e=0 i=00900113", fetch_valid, fetch_err, fetch_instr);
        end
        // A hold also keeps valid low when it is already low
        fetch_req = 1'b0;
        step();
        fetch_hold = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h8;
        step();
        tests_run++;
        if (fetch_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_keeps_invalid: got v=%b, need v=0", fetch_valid);
        end
        idle_inputs();
    endtask

    task automatic test_fill_restart();
        int n;
        release_reset();
        for (int i = 0; i < 10; i++) step();
        assert_reset();
        tests_run++;
        if ({fill_busy, fetch_ready, fetch_valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL midfill_reset: got busy=%b rdy=%b v=%b, need busy=1 rdy=0 v=0", fill_busy, fetch_ready, fetch_valid);
        end
        release_reset();
        n = 0;
        while (fill_busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        tests_run++;
        if (n != 32 || fetch_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL refill_cycles: got %0d cycles ready=%b, need 32 ready=1", n, fetch_ready);
        end
        fetch_req = 1'b1; fetch_addr = 32'h8;
        step();
        tests_run++;
        if ({fetch_valid, fetch_err, fetch_instr} !== {2'b10, HALT}) begin
            tests_failed++;
            $display("FAIL refill_content: got v=%b e=%b i=%h, need v=1 e=0 i=%h", fetch_valid, fetch_err, fetch_instr, HALT);
        end
        idle_inputs();
    endtask

`ifdef IMEM_PARITY_EN
    task automatic test_parity();
        logic [31:0] addrs[4] = '{32'h14, 32'h18, 32'h15, 32'h14};
        logic        perrs[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        load_we = 1'b1; load_addr = 5'd5; load_data = 32'h12345678; load_perr_inj = 1'b1;
        step();
        load_addr = 5'd6; load_data = 32'h0badf00d; load_perr_inj = 1'b0;
        step();
        load_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fetch_req = 1'b1; fetch_addr = addrs[i];
            step();
            tests_run++;
            if (fetch_perr !== perrs[i]) begin
                tests_failed++;
                $display("FAIL parity %h: got perr=%b, need %b", addrs[i], fetch_perr, perrs[i]);
            end
        end
        fetch_hold = 1'b1; fetch_addr = 32'h18;
        step();
        tests_run++;
        if (fetch_perr !== 1'b1) begin
            tests_failed++;
            $display("FAIL parity_hold: got perr=%b, need 1", fetch_perr);
        end
        idle_inputs();
    endtask
`endif

    task automatic test_random();
        int kind;
        for (int c = 0; c < 400; c++) begin
            fetch_hold    = ($urandom_range(0, 4) == 0);
            fetch_req     = ($urandom_range(0, 9) < 7);
            load_we       = ($urandom_range(0, 9) < 4);
            load_addr     = 5'($urandom_range(0, DEPTH - 1));
            load_data     = $urandom;
            load_perr_inj = ($urandom_range(0, 3) == 0);
            kind          = $urandom_range(0, 19);
            if (kind < 14)      fetch_addr = 32'($urandom_range(0, DEPTH - 1)) * 4;
            else if (kind < 17) fetch_addr = ($urandom & 32'hfc) | 32'($urandom_range(1, 3));
            else                fetch_addr = ($urandom | 32'h80) & 32'hfffffffc;
            step();
            tests_run++;
            if ({fetch_valid, fetch_err, fetch_instr, fetch_ready, fill_busy}
                    !== {exp_valid, exp_err, exp_instr, 2'b10}) begin
                tests_failed++;
                $display("FAIL random %0d: got v=%b e=%b i=%h rdy=%b busy=%b, need v=%b e=%b i=%h rdy=1 busy=0",
                         c, fetch_valid, fetch_err, fetch_instr, fetch_ready, fill_busy,
                         exp_valid, exp_err, exp_instr);
            end
`ifdef IMEM_PARITY_EN
            tests_run++;
            if (fetch_perr !== exp_perr) begin
                tests_failed++;
                $display("FAIL random_perr %0d: got %b, need %b", c, fetch_perr, exp_perr);
            end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_load_fetch();
        test_errors();
        test_read_before_write();
        test_hold();
`ifdef IMEM_PARITY_EN
        test_parity();
`endif
        test_random();
        assert_reset();
        test_fill_restart();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
